// File: rtl/instr_fetch_unit.sv
// Purpose : program counter plus IF/ID register; feeds instruction memory and decode.
// Latency : word at pc appears in if_instr/if_valid on the next rising edge.
// Backpressure: stall freezes pc and IF/ID; redirect beats stall; halt word stops fetch.
module instr_fetch_unit #(
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned IMEM_DEPTH  = 1024,
  parameter int unsigned BOOT_CYCLES = 4,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // PC width covers exactly the memory index range.
  localparam int unsigned AW  = (IMEM_DEPTH < 2) ? 1 : $clog2(IMEM_DEPTH);
  // Boot counter must be able to hold the value BOOT_CYCLES itself.
  localparam int unsigned BCW = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_q;
  logic [BCW-1:0]  boot_cnt_q;
  logic [AW-1:0]   pc_q;
  logic [AW-1:0]   pc_inc_d;
  logic [AW-1:0]   redirect_pc_d;
  logic [31:0]     if_instr_q;
  logic [31:0]     if_pc_q;
  logic            if_valid_q;
  logic            halted_q;
  logic [31:0]     fetch_count_q;
  logic            unused_target_bits;

  // Sequential successor of the PC, wrapping at the last memory word.
  assign pc_inc_d = (pc_q == AW'(IMEM_DEPTH - 1)) ? '0 : pc_q + AW'(1);

  // Only the low index bits of a redirect target are meaningful.
  assign redirect_pc_d      = redirect_target[AW-1:0];
  assign unused_target_bits = ^redirect_target[31:AW];

  // Memory address is the PC itself, zero-extended.
  assign imem_addr = {{(32 - AW){1'b0}}, pc_q};

  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_valid    = if_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

  // Fetch FSM: boot delay, then fetch with redirect > stall > halt > issue priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= '0;
      pc_q          <= AW'(RESET_PC);
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          // Inputs are ignored; leave after BOOT_CYCLES counted edges.
          if_valid_q <= 1'b0;
          if (boot_cnt_q == BCW'(BOOT_CYCLES)) begin
            state_q <= ST_RUN;
          end else begin
            boot_cnt_q <= boot_cnt_q + BCW'(1);
          end
        end
        ST_RUN: begin
          if (redirect_valid) begin
            // Squash the in-flight word; the target is fetched next cycle.
            pc_q       <= redirect_pc_d;
            if_valid_q <= 1'b0;
          end else if (stall) begin
            // Decode is busy: hold everything.
            pc_q <= pc_q;
          end else if (imem_instr == HALT_WORD) begin
            // pc keeps pointing at the halt word, which is never issued.
            state_q    <= ST_HALT;
            halted_q   <= 1'b1;
            if_valid_q <= 1'b0;
          end else begin
            if_instr_q    <= imem_instr;
            if_pc_q       <= {{(32 - AW){1'b0}}, pc_q};
            if_valid_q    <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
            pc_q          <= pc_inc_d;
          end
        end
        ST_HALT: begin
          // Terminal until reset.
          if_valid_q <= 1'b0;
          halted_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : directed check of instr_fetch_unit against hand-computed per-edge expectations.
// Latency : inputs driven on the falling edge, outputs sampled on the next falling edge.
// Backpressure: stall/redirect vectors are part of the table.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [1024];

  int n_checks;
  int n_fail;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_fc;
    logic [31:0] e_addr;
    logic        e_halted;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit #(
    .RESET_PC   (0),
    .IMEM_DEPTH (1024),
    .BOOT_CYCLES(4),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_instr     (imem_instr),
    .imem_addr      (imem_addr),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign imem_instr = (imem_addr < 32'd1024) ? mem[imem_addr[9:0]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic s, input logic rv, input logic [31:0] tgt,
                      input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] fc, input logic [31:0] addr, input logic h);
    vec_t t;
    t.stall = s; t.rv = rv; t.tgt = tgt;
    t.e_valid = v; t.e_pc = pc; t.e_instr = ins; t.e_fc = fc; t.e_addr = addr; t.e_halted = h;
    vecs.push_back(t);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | i;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33;
    mem[3] = 32'd44; mem[4] = 32'd55; mem[5] = 32'hFFFF_FFFF;

    // Per-edge vectors, edge 1 = first rising edge after reset release.
    //    stall rv  target         valid pc    instr          fc  addr  halted
    addv(0, 0, 32'd0,          0, 0,    0,             0,  0,    0); // e1 boot
    addv(1, 0, 32'd0,          0, 0,    0,             0,  0,    0); // e2 stall ignored
    addv(0, 1, 32'd50,         0, 0,    0,             0,  0,    0); // e3 redirect ignored
    addv(0, 0, 32'd0,          0, 0,    0,             0,  0,    0); // e4
    addv(0, 0, 32'd0,          0, 0,    0,             0,  0,    0); // e5 enter RUN
    addv(0, 0, 32'd0,          1, 0,    32'd11,        1,  1,    0); // e6 first issue
    addv(0, 0, 32'd0,          1, 1,    32'd22,        2,  2,    0); // e7
    addv(1, 0, 32'd0,          1, 1,    32'd22,        2,  2,    0); // e8 stall
    addv(1, 0, 32'd0,          1, 1,    32'd22,        2,  2,    0); // e9 stall
    addv(1, 0, 32'd0,          1, 1,    32'd22,        2,  2,    0); // e10 stall
    addv(0, 0, 32'd0,          1, 2,    32'd33,        3,  3,    0); // e11 release
    addv(1, 1, 32'hABCD_0064,  0, 2,    32'd33,        3,  100,  0); // e12 redirect+stall, masked
    addv(0, 0, 32'd0,          1, 100,  32'hC000_0064, 4,  101,  0); // e13
    addv(0, 0, 32'd0,          1, 101,  32'hC000_0065, 5,  102,  0); // e14
    addv(0, 1, 32'd1023,       0, 101,  32'hC000_0065, 5,  1023, 0); // e15 redirect to top
    addv(0, 0, 32'd0,          1, 1023, 32'hC000_03FF, 6,  0,    0); // e16 wrap
    addv(0, 0, 32'd0,          1, 0,    32'd11,        7,  1,    0); // e17
    addv(0, 0, 32'd0,          1, 1,    32'd22,        8,  2,    0); // e18
    addv(0, 0, 32'd0,          1, 2,    32'd33,        9,  3,    0); // e19
    addv(0, 0, 32'd0,          1, 3,    32'd44,        10, 4,    0); // e20
    addv(0, 0, 32'd0,          1, 4,    32'd55,        11, 5,    0); // e21
    addv(0, 0, 32'd0,          0, 4,    32'd55,        11, 5,    1); // e22 halt word seen
    addv(1, 1, 32'd0,          0, 4,    32'd55,        11, 5,    1); // e23 ignored in HALT
    addv(0, 1, 32'd7,          0, 4,    32'd55,        11, 5,    1); // e24 ignored in HALT

    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;

    // Reset state while rst_n is held low.
    #12;
    check("rst_if_valid",    {31'd0, if_valid}, 32'd0);
    check("rst_halted",      {31'd0, halted},   32'd0);
    check("rst_fetch_count", fetch_count,       32'd0);
    check("rst_imem_addr",   imem_addr,         32'd0);
    check("rst_if_pc",       if_pc,             32'd0);
    check("rst_if_instr",    if_instr,          32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      stall           = vecs[k].stall;
      redirect_valid  = vecs[k].rv;
      redirect_target = vecs[k].tgt;
      @(negedge clk);
      check($sformatf("e%0d_if_valid", k + 1),    {31'd0, if_valid}, {31'd0, vecs[k].e_valid});
      check($sformatf("e%0d_if_pc", k + 1),       if_pc,             vecs[k].e_pc);
      check($sformatf("e%0d_if_instr", k + 1),    if_instr,          vecs[k].e_instr);
      check($sformatf("e%0d_fetch_count", k + 1), fetch_count,       vecs[k].e_fc);
      check($sformatf("e%0d_imem_addr", k + 1),   imem_addr,         vecs[k].e_addr);
      check($sformatf("e%0d_halted", k + 1),      {31'd0, halted},   {31'd0, vecs[k].e_halted});
    end

    // Leave HALT by reset, get back into RUN and issue a couple of words.
    stall          = 1'b0;
    redirect_valid = 1'b0;
    rst_n          = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check("rerun_if_pc",  if_pc,       32'd1);
    check("rerun_fc",     fetch_count, 32'd2);

    // Asynchronous reset asserted between edges must act immediately.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_if_valid",    {31'd0, if_valid}, 32'd0);
    check("async_fetch_count", fetch_count,       32'd0);
    check("async_imem_addr",   imem_addr,         32'd0);
    check("async_if_pc",       if_pc,             32'd0);
    check("async_if_instr",    if_instr,          32'd0);
    check("async_halted",      {31'd0, halted},   32'd0);

    // Re-enter BOOT: still a bubble on edge 5, first issue from RESET_PC on edge 6.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reboot_e5_if_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    check("reboot_e6_if_valid", {31'd0, if_valid}, 32'd1);
    check("reboot_e6_if_pc",    if_pc,             32'd0);
    check("reboot_e6_if_instr", if_instr,          32'd11);
    check("reboot_e6_fc",       fetch_count,       32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
